// File: rtl/mem_access_master_pkg.sv
// Shared encodings for the RAM initiator, its RAM model and the bench.
// States, RAM depth and load/store op codes live here.
package mem_access_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_RECOVER = 3'd3,
        ST_ERR     = 3'd4
    } state_t;

    localparam int   MEM_WORDS = 512;
    localparam logic OP_LOAD   = 1'b0;
    localparam logic OP_STORE  = 1'b1;

endpackage

// File: rtl/mem_access_master.sv
// Initiator for the level-triggered word RAM: one load/store at a time,
// with setup, strobe and recovery phases so the RAM sees clean edges.
module mem_access_master
    import mem_access_master_pkg::*;
#(
    parameter int ADDR_W        = 9,
    parameter int DATA_W        = 32,
    parameter int STROBE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [31:0]       mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_q
);

    localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYCLES - 1);

    state_t              r_state, w_state_nx;
    logic [3:0]          r_cnt, w_cnt_nx;
    logic                r_op, w_op_nx;
    logic                r_ready, w_ready_nx;
    logic                r_rsp_valid, w_rsp_valid_nx;
    logic                r_rsp_err, w_rsp_err_nx;
    logic [DATA_W-1:0]   r_rdata, w_rdata_nx;
    logic [31:0]         r_addr, w_addr_nx;
    logic [DATA_W-1:0]   r_wdata, w_wdata_nx;
    logic                r_read, w_read_nx;
    logic                r_write, w_write_nx;

    logic                w_accept;
    logic                w_oob;
    logic                w_last;

    assign w_accept = req_valid & r_ready;
    // Any set bit above the implemented range is out of range.
    assign w_oob    = |req_addr[31:ADDR_W];
    assign w_last   = (r_state == ST_STROBE) && (r_cnt == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_op        <= OP_LOAD;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rdata     <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_op        <= w_op_nx;
            r_ready     <= w_ready_nx;
            r_rsp_valid <= w_rsp_valid_nx;
            r_rsp_err   <= w_rsp_err_nx;
            r_rdata     <= w_rdata_nx;
            r_addr      <= w_addr_nx;
            r_wdata     <= w_wdata_nx;
            r_read      <= w_read_nx;
            r_write     <= w_write_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nx = w_oob ? ST_ERR : ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_nx = ST_STROBE;
                w_cnt_nx   = CNT_LOAD;
            end
            ST_STROBE: begin
                if (r_cnt == 4'd0) begin
                    w_state_nx = ST_RECOVER;
                end else begin
                    w_cnt_nx = r_cnt - 4'd1;
                end
            end
            ST_RECOVER: w_state_nx = ST_IDLE;
            ST_ERR:     w_state_nx = ST_IDLE;
            default:    w_state_nx = ST_IDLE;
        endcase
    end

    // Registered outputs are decoded from the state being entered.
    always_comb begin
        w_op_nx        = w_accept ? req_write : r_op;
        w_addr_nx      = w_accept ? req_addr  : r_addr;
        w_wdata_nx     = w_accept ? req_wdata : r_wdata;
        w_ready_nx     = (w_state_nx == ST_IDLE);
        w_rsp_valid_nx = (w_state_nx == ST_RECOVER) ||
                         (w_state_nx == ST_ERR);
        w_rsp_err_nx   = (w_state_nx == ST_ERR);
        w_read_nx      = (w_state_nx == ST_STROBE) &&
                         (w_op_nx == OP_LOAD);
        w_write_nx     = (w_state_nx == ST_STROBE) &&
                         (w_op_nx == OP_STORE);
        w_rdata_nx     = (w_last && r_op == OP_LOAD) ? mem_q : r_rdata;
    end

    assign req_ready   = r_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_err     = r_rsp_err;
    assign rsp_rdata   = r_rdata;
    assign mem_address = r_addr;
    assign mem_wdata   = r_wdata;
    assign mem_read    = r_read;
    assign mem_write   = r_write;

endmodule

// File: tb/tb_mem_access_master.sv
// Directed bench for mem_access_master with a RAM model and a
// response scoreboard; a second instance covers a 3-cycle strobe.
module tb_mem_access_master;
    import mem_access_master_pkg::*;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_q;

    logic        d3_req_valid;
    logic [31:0] d3_req_addr;
    logic        d3_req_ready;
    logic        d3_rsp_valid;
    logic        d3_rsp_err;
    logic [31:0] d3_rsp_rdata;
    logic [31:0] d3_mem_address;
    logic [31:0] d3_mem_wdata;
    logic        d3_mem_read;
    logic        d3_mem_write;
    logic [31:0] d3_mem_q;

    mem_access_master dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_q(mem_q)
    );

    mem_access_master #(.STROBE_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(d3_req_valid), .req_write(1'b0),
        .req_addr(d3_req_addr), .req_wdata(32'h0),
        .req_ready(d3_req_ready), .rsp_valid(d3_rsp_valid),
        .rsp_err(d3_rsp_err), .rsp_rdata(d3_rsp_rdata),
        .mem_address(d3_mem_address), .mem_wdata(d3_mem_wdata),
        .mem_read(d3_mem_read), .mem_write(d3_mem_write),
        .mem_q(d3_mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] ram [MEM_WORDS];
    logic [31:0] model [MEM_WORDS];

    always @(posedge clk) begin
        if (mem_write) ram[mem_address[8:0]] <= mem_wdata;
    end
    assign mem_q    = ram[mem_address[8:0]];
    assign d3_mem_q = {d3_mem_address[15:0], ~d3_mem_address[15:0]};

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          hi_run   = 0;
    int          lo_run   = 100;
    int          prev_acc = 0;
    logic [31:0] exp_rdata = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response scoreboard plus strobe-shape monitor.
    always @(negedge clk) begin
        exp_t e;
        check("rw_exclusive", {31'h0, mem_read & mem_write}, 32'h0);
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'h1, 32'h0);
            end else begin
                e = sb.pop_front();
                check("rsp_cycle", cyc, e.due);
                check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                check("rsp_rdata", rsp_rdata, e.rdata);
            end
        end
        if (mem_read | mem_write) begin
            hi_run++;
            if (hi_run == 1) check("strobe_gap_ge2", {31'h0, lo_run >= 2}, 32'h1);
            lo_run = 0;
        end else begin
            if (hi_run > 0) check("strobe_len", hi_run, 1);
            hi_run = 0;
            lo_run++;
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic w, input logic [31:0] a,
                         input logic [31:0] d, input bit hold,
                         input bit chk_gap);
        bit oob;
        exp_t e;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        if (!req_ready) begin
            check("accept_timeout", 32'h1, 32'h0);
        end else begin
            oob = (a >= MEM_WORDS);
            if (chk_gap) check("accept_spacing", cyc - prev_acc, 4);
            prev_acc = cyc;
            if (!oob) begin
                if (w) model[a[8:0]] = d;
                else   exp_rdata = model[a[8:0]];
            end
            e.due   = cyc + (oob ? 1 : 3);
            e.err   = oob;
            e.rdata = exp_rdata;
            sb.push_back(e);
            @(negedge clk);
            if (!hold) req_valid = 1'b0;
            if (oob) check("err_no_strobe",
                           {30'h0, mem_read, mem_write}, 32'h0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int          a3;
        int          got3;
        int          rd3;
        logic [31:0] rdata3;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        d3_req_valid = 1'b0;
        d3_req_addr  = 32'h0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            ram[i]   = 32'h0;
            model[i] = 32'h0;
        end
        ram[9'h095] = 32'hAAAAAAAA; model[9'h095] = 32'hAAAAAAAA;
        ram[9'h1FF] = 32'hDEADBEEF; model[9'h1FF] = 32'hDEADBEEF;
        ram[9'h038] = 32'h38383838; model[9'h038] = 32'h38383838;
        ram[9'h039] = 32'h39393939; model[9'h039] = 32'h39393939;
        repeat (2) @(negedge clk);

        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_mem_address", mem_address, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_read", {31'h0, mem_read}, 32'h0);
        check("rst_mem_write", {31'h0, mem_write}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        issue(1'b0, 32'h95, 32'h0, 1'b0, 1'b0);
        drain();

        issue(1'b1, 32'h87, 32'h12345678, 1'b0, 1'b0);
        drain();
        check("store_addr_held", mem_address, 32'h87);
        check("store_wdata_held", mem_wdata, 32'h12345678);
        issue(1'b0, 32'h87, 32'h0, 1'b0, 1'b0);
        drain();

        issue(1'b0, 32'h200, 32'h0, 1'b0, 1'b0);
        issue(1'b0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
        issue(1'b0, 32'h1FF, 32'h0, 1'b0, 1'b0);
        drain();

        issue(1'b0, 32'h38, 32'h0, 1'b1, 1'b0);
        issue(1'b0, 32'h39, 32'h0, 1'b1, 1'b1);
        issue(1'b0, 32'h38, 32'h0, 1'b0, 1'b1);
        drain();

        issue(1'b1, 32'h10, 32'hCAFEF00D, 1'b0, 1'b0);
        @(negedge clk);
        check("store_strobe_up", {31'h0, mem_write}, 32'h1);
        reset = 1'b1;
        #1;
        check("rst_async_write", {31'h0, mem_write}, 32'h0);
        check("rst_async_valid", {31'h0, rsp_valid}, 32'h0);
        sb.delete();
        exp_rdata = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_ready_after", {31'h0, req_ready}, 32'h1);

        check("sc3_ready", {31'h0, d3_req_ready}, 32'h1);
        d3_req_valid = 1'b1;
        d3_req_addr  = 32'h40;
        a3   = cyc;
        got3 = -1;
        rd3  = 0;
        rdata3 = 32'h0;
        @(negedge clk);
        d3_req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (d3_mem_read) rd3++;
            if (d3_mem_write) rd3 += 100;
            if (d3_rsp_valid && got3 < 0) begin
                got3   = cyc;
                rdata3 = d3_rsp_rdata;
                check("sc3_err", {31'h0, d3_rsp_err}, 32'h0);
            end
            @(negedge clk);
        end
        check("sc3_read_len", rd3, 3);
        check("sc3_latency", got3 - a3, 5);
        check("sc3_rdata", rdata3, 32'h0040FFBF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
